rvfi_shadow_pipe: RTL and testbench

//  Parametrised RVFI shadow pipeline for the pipelined core bench. Carries per-instruction

---
 rtl/rvfi_shadow_pipe_if.sv | 67 ++++++
 rtl/rvfi_shadow_pipe.sv | 166 ++++++++++++++++
 tb/tb_rvfi_shadow_pipe.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rvfi_shadow_pipe_if.sv
// rvfi_shadow_pipe_if
//   Bundles the datapath probe inputs and the RVFI commit outputs of the
//   shadow pipeline.
//   master : the core/bench side; drives hold/flush, capture, redirect,
//            memory and writeback probes; observes the commit packet.
//   slave  : the shadow pipeline itself.
//   Commit semantics: cmt_valid is a one-cycle strobe with no back-pressure.
//   Every cmt_* field is meaningful only while cmt_valid is high and is 0
//   otherwise. Each strobe retires exactly one instruction.
interface rvfi_shadow_pipe_if #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 3,
  parameter int ORDER_W = 64
);
  logic [DEPTH-1:0]   hold;
  logic [DEPTH-1:0]   flush;
  logic               cap_valid;
  logic [XLEN-1:0]    cap_pc;
  logic [31:0]        cap_inst;
  logic [XLEN-1:0]    cap_rs1_rdata;
  logic [XLEN-1:0]    cap_rs2_rdata;
  logic               rdr_valid;
  logic [XLEN-1:0]    rdr_target;
  logic [XLEN-1:0]    mem_addr;
  logic [3:0]         mem_rmask;
  logic [3:0]         mem_wmask;
  logic [XLEN-1:0]    mem_rdata;
  logic [XLEN-1:0]    mem_wdata;
  logic               wb_load;
  logic [4:0]         wb_rd;
  logic [XLEN-1:0]    wb_wdata;

  logic               cmt_valid;
  logic [ORDER_W-1:0] cmt_order;
  logic [XLEN-1:0]    cmt_pc_rdata;
  logic [XLEN-1:0]    cmt_pc_wdata;
  logic [31:0]        cmt_inst;
  logic [XLEN-1:0]    cmt_rs1_rdata;
  logic [XLEN-1:0]    cmt_rs2_rdata;
  logic [4:0]         cmt_rd_addr;
  logic [XLEN-1:0]    cmt_rd_wdata;
  logic [XLEN-1:0]    cmt_mem_addr;
  logic [3:0]         cmt_mem_rmask;
  logic [3:0]         cmt_mem_wmask;
  logic [XLEN-1:0]    cmt_mem_rdata;
  logic [XLEN-1:0]    cmt_mem_wdata;
  logic               cmt_trap;
  logic               halt;

  modport master (
    output hold, flush, cap_valid, cap_pc, cap_inst, cap_rs1_rdata, cap_rs2_rdata,
           rdr_valid, rdr_target, mem_addr, mem_rmask, mem_wmask, mem_rdata,
           mem_wdata, wb_load, wb_rd, wb_wdata,
    input  cmt_valid, cmt_order, cmt_pc_rdata, cmt_pc_wdata, cmt_inst,
           cmt_rs1_rdata, cmt_rs2_rdata, cmt_rd_addr, cmt_rd_wdata, cmt_mem_addr,
           cmt_mem_rmask, cmt_mem_wmask, cmt_mem_rdata, cmt_mem_wdata, cmt_trap, halt
  );

  modport slave (
    input  hold, flush, cap_valid, cap_pc, cap_inst, cap_rs1_rdata, cap_rs2_rdata,
           rdr_valid, rdr_target, mem_addr, mem_rmask, mem_wmask, mem_rdata,
           mem_wdata, wb_load, wb_rd, wb_wdata,
    output cmt_valid, cmt_order, cmt_pc_rdata, cmt_pc_wdata, cmt_inst,
           cmt_rs1_rdata, cmt_rs2_rdata, cmt_rd_addr, cmt_rd_wdata, cmt_mem_addr,
           cmt_mem_rmask, cmt_mem_wmask, cmt_mem_rdata, cmt_mem_wdata, cmt_trap, halt
  );
endinterface

// File: rtl/rvfi_shadow_pipe.sv
// rvfi_shadow_pipe
//   Shadow pipeline carrying RVFI monitor metadata through DEPTH stages in
//   lock-step with the core datapath. Stage 0 captures, stage DEPTH-1 commits.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset (drops all in-flight entries)
//     bus   : rvfi_shadow_pipe_if.slave (probes in, commit packet out)
//   Optional feature: define RVFI_HALT_DETECT_EN to enable the sticky
//   infinite-loop detector on bus.halt; otherwise halt is tied 0.
//   No FSM: the only state is the per-stage entry storage, the order counter
//   and (optionally) the halt flag.
module rvfi_shadow_pipe #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 3,
  parameter int MEM_IDX = 1,
  parameter int BR_IDX  = 0,
  parameter int ORDER_W = 64
) (
  input logic               clk,
  input logic               rst_n,
  rvfi_shadow_pipe_if.slave bus
);

  logic            valid_q  [DEPTH];
  logic [XLEN-1:0] pc_q     [DEPTH];
  logic [XLEN-1:0] npc_q    [DEPTH];
  logic [31:0]     inst_q   [DEPTH];
  logic [XLEN-1:0] rs1_q    [DEPTH];
  logic [XLEN-1:0] rs2_q    [DEPTH];
  logic [XLEN-1:0] maddr_q  [DEPTH];
  logic [3:0]      rmask_q  [DEPTH];
  logic [3:0]      wmask_q  [DEPTH];
  logic [XLEN-1:0] mrdata_q [DEPTH];
  logic [XLEN-1:0] mwdata_q [DEPTH];

  logic [ORDER_W-1:0] order_q;
  logic               cmt_fire;

  localparam int LAST = DEPTH - 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        pc_q[i]     <= '0;
        npc_q[i]    <= '0;
        inst_q[i]   <= '0;
        rs1_q[i]    <= '0;
        rs2_q[i]    <= '0;
        maddr_q[i]  <= '0;
        rmask_q[i]  <= '0;
        wmask_q[i]  <= '0;
        mrdata_q[i] <= '0;
        mwdata_q[i] <= '0;
      end
    end else begin
      if (!bus.hold[0]) begin
        valid_q[0]  <= bus.cap_valid;
        pc_q[0]     <= bus.cap_pc;
        npc_q[0]    <= bus.cap_pc + XLEN'(4);
        inst_q[0]   <= bus.cap_inst;
        rs1_q[0]    <= bus.cap_rs1_rdata;
        rs2_q[0]    <= bus.cap_rs2_rdata;
        maddr_q[0]  <= '0;
        rmask_q[0]  <= '0;
        wmask_q[0]  <= '0;
        mrdata_q[0] <= '0;
        mwdata_q[0] <= '0;
      end
      if (bus.flush[0]) valid_q[0] <= 1'b0;

      for (int i = 1; i < DEPTH; i++) begin
        if (!bus.hold[i]) begin
          if (bus.hold[i-1]) begin
            // Upstream is frozen: this stage moves on but receives a bubble.
            valid_q[i] <= 1'b0;
          end else begin
            valid_q[i]  <= valid_q[i-1];
            pc_q[i]     <= pc_q[i-1];
            npc_q[i]    <= npc_q[i-1];
            inst_q[i]   <= inst_q[i-1];
            rs1_q[i]    <= rs1_q[i-1];
            rs2_q[i]    <= rs2_q[i-1];
            maddr_q[i]  <= maddr_q[i-1];
            rmask_q[i]  <= rmask_q[i-1];
            wmask_q[i]  <= wmask_q[i-1];
            mrdata_q[i] <= mrdata_q[i-1];
            mwdata_q[i] <= mwdata_q[i-1];
            // Redirect and memory probes belong to the entry leaving their
            // stage, so they are sampled only on a real transfer.
            if ((i - 1) == BR_IDX && bus.rdr_valid) npc_q[i] <= bus.rdr_target;
            if ((i - 1) == MEM_IDX) begin
              maddr_q[i]  <= bus.mem_addr;
              rmask_q[i]  <= bus.mem_rmask;
              wmask_q[i]  <= bus.mem_wmask;
              mrdata_q[i] <= bus.mem_rdata;
              mwdata_q[i] <= bus.mem_wdata;
            end
          end
        end
        // Flush wins over hold.
        if (bus.flush[i]) valid_q[i] <= 1'b0;
      end
    end
  end

  assign cmt_fire = valid_q[LAST] & ~bus.hold[LAST] & ~bus.flush[LAST];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        order_q <= '0;
    else if (cmt_fire) order_q <= order_q + ORDER_W'(1);
  end

  always_comb begin
    bus.cmt_valid     = 1'b0;
    bus.cmt_order     = '0;
    bus.cmt_pc_rdata  = '0;
    bus.cmt_pc_wdata  = '0;
    bus.cmt_inst      = '0;
    bus.cmt_rs1_rdata = '0;
    bus.cmt_rs2_rdata = '0;
    bus.cmt_rd_addr   = '0;
    bus.cmt_rd_wdata  = '0;
    bus.cmt_mem_addr  = '0;
    bus.cmt_mem_rmask = '0;
    bus.cmt_mem_wmask = '0;
    bus.cmt_mem_rdata = '0;
    bus.cmt_mem_wdata = '0;
    bus.cmt_trap      = 1'b0;
    if (cmt_fire) begin
      bus.cmt_valid     = 1'b1;
      bus.cmt_order     = order_q;
      bus.cmt_pc_rdata  = pc_q[LAST];
      bus.cmt_pc_wdata  = npc_q[LAST];
      bus.cmt_inst      = inst_q[LAST];
      bus.cmt_rs1_rdata = rs1_q[LAST];
      bus.cmt_rs2_rdata = rs2_q[LAST];
      bus.cmt_rd_addr   = bus.wb_load ? bus.wb_rd : 5'd0;
      // x0 writes are reported as zero data.
      bus.cmt_rd_wdata  = (bus.wb_load && bus.wb_rd != 5'd0) ? bus.wb_wdata : '0;
      bus.cmt_mem_addr  = maddr_q[LAST];
      bus.cmt_mem_rmask = rmask_q[LAST];
      bus.cmt_mem_wmask = wmask_q[LAST];
      bus.cmt_mem_rdata = mrdata_q[LAST];
      bus.cmt_mem_wdata = mwdata_q[LAST];
      bus.cmt_trap      = (inst_q[LAST][6:0] == 7'd0);
    end
  end

`ifdef RVFI_HALT_DETECT_EN
  // A retired instruction whose next pc is its own pc is a self-loop.
  logic halt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halt_q <= 1'b0;
    else if (cmt_fire && npc_q[LAST] == pc_q[LAST] && pc_q[LAST] != '0) halt_q <= 1'b1;
  end
  assign bus.halt = halt_q;
`else
  assign bus.halt = 1'b0;
`endif

  // A stage may only be held if every older-to-younger upstream stage is too.
  hold_monotone: assert property (@(posedge clk) disable iff (!rst_n)
    ((bus.hold >> 1) & ~bus.hold) == '0);

endmodule

// File: tb/tb_rvfi_shadow_pipe.sv
module tb_rvfi_shadow_pipe;

  localparam int XLEN = 32;
  localparam int DEPTH = 3;
  localparam int ORDER_W = 64;
`ifdef RVFI_HALT_DETECT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  rvfi_shadow_pipe_if #(.XLEN(XLEN), .DEPTH(DEPTH), .ORDER_W(ORDER_W)) bus ();

  rvfi_shadow_pipe #(
    .XLEN(XLEN), .DEPTH(DEPTH), .MEM_IDX(1), .BR_IDX(0), .ORDER_W(ORDER_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] exp_pc;
  logic [ORDER_W-1:0] exp_order;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.hold = '0;
    bus.flush = '0;
    bus.cap_valid = 1'b0;
    bus.cap_pc = '0;
    bus.cap_inst = '0;
    bus.cap_rs1_rdata = '0;
    bus.cap_rs2_rdata = '0;
    bus.rdr_valid = 1'b0;
    bus.rdr_target = '0;
    bus.mem_addr = '0;
    bus.mem_rmask = '0;
    bus.mem_wmask = '0;
    bus.mem_rdata = '0;
    bus.mem_wdata = '0;
    bus.wb_load = 1'b0;
    bus.wb_rd = '0;
    bus.wb_wdata = '0;
  endtask

  task automatic cap_in(input logic [XLEN-1:0] pc, input logic [31:0] inst);
    bus.cap_valid = 1'b1;
    bus.cap_pc = pc;
    bus.cap_inst = inst;
    bus.cap_rs1_rdata = pc + 32'h1000;
    bus.cap_rs2_rdata = pc + 32'h2000;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    rst_n = 1'b0;
    exp_order = '0;
    tick();
    tick();
    check_eq("rst_cmt_valid", bus.cmt_valid, 1'b0);
    check_eq("rst_cmt_order", bus.cmt_order, 64'd0);
    check_eq("rst_cmt_pc", bus.cmt_pc_rdata, 32'd0);
    check_eq("rst_halt", bus.halt, 1'b0);
    rst_n = 1'b1;
    tick();

    // Back-to-back captures: commits after edges 3,4,5.
    exp_q.push_back(32'h60);
    exp_q.push_back(32'h64);
    exp_q.push_back(32'h68);
    for (int k = 1; k <= 6; k++) begin
      if (k <= 3) cap_in(32'h60 + 32'(4 * (k - 1)), 32'h0000_0013);
      else bus.cap_valid = 1'b0;
      tick();
      check_eq($sformatf("b2b_valid_c%0d", k), bus.cmt_valid, (k >= 3 && k <= 5));
      if (bus.cmt_valid && exp_q.size() > 0) begin
        exp_pc = exp_q.pop_front();
        check_eq("b2b_pc", bus.cmt_pc_rdata, exp_pc);
        check_eq("b2b_pc_wdata", bus.cmt_pc_wdata, exp_pc + 32'd4);
        check_eq("b2b_rs1", bus.cmt_rs1_rdata, exp_pc + 32'h1000);
        check_eq("b2b_order", bus.cmt_order, exp_order);
        check_eq("b2b_trap", bus.cmt_trap, 1'b0);
        exp_order++;
      end
    end
    check_eq("b2b_drained", exp_q.size(), 0);

    // hold=011 with entry at stage1: stage2 bubbles for two cycles.
    cap_in(32'h70, 32'h0000_0013);
    tick();
    bus.cap_valid = 1'b0;
    tick();
    bus.hold = 3'b011;
    check_eq("hold_pre_valid", bus.cmt_valid, 1'b0);
    tick();
    check_eq("hold_bubble1", bus.cmt_valid, 1'b0);
    tick();
    check_eq("hold_bubble2", bus.cmt_valid, 1'b0);
    bus.hold = 3'b000;
    tick();
    check_eq("hold_release_valid", bus.cmt_valid, 1'b1);
    check_eq("hold_release_pc", bus.cmt_pc_rdata, 32'h70);
    check_eq("hold_order", bus.cmt_order, exp_order);
    exp_order++;
    tick();

    // Redirect out of stage0 plus flush[0] drops the younger capture.
    cap_in(32'h64, 32'h0000_0013);
    tick();
    cap_in(32'h68, 32'h0000_0013);
    bus.rdr_valid = 1'b1;
    bus.rdr_target = 32'h100;
    bus.flush = 3'b001;
    tick();
    bus.cap_valid = 1'b0;
    bus.rdr_valid = 1'b0;
    bus.rdr_target = 32'h0;
    bus.flush = 3'b000;
    check_eq("rdr_pre_valid", bus.cmt_valid, 1'b0);
    tick();
    check_eq("rdr_valid", bus.cmt_valid, 1'b1);
    check_eq("rdr_pc", bus.cmt_pc_rdata, 32'h64);
    check_eq("rdr_pc_wdata", bus.cmt_pc_wdata, 32'h100);
    check_eq("rdr_order", bus.cmt_order, exp_order);
    exp_order++;
    tick();
    check_eq("rdr_younger_dropped", bus.cmt_valid, 1'b0);
    tick();
    check_eq("rdr_still_empty", bus.cmt_valid, 1'b0);

    // Store: memory probes sampled as it leaves stage1.
    cap_in(32'h90, 32'h0011_2023);
    tick();
    bus.cap_valid = 1'b0;
    tick();
    bus.mem_addr = 32'h2000;
    bus.mem_wmask = 4'hF;
    bus.mem_wdata = 32'hDEAD_BEEF;
    bus.mem_rmask = 4'h0;
    bus.mem_rdata = 32'h0;
    tick();
    bus.mem_addr = 32'hBAD0;
    bus.mem_wmask = 4'h0;
    bus.mem_wdata = 32'h0;
    check_eq("sw_valid", bus.cmt_valid, 1'b1);
    check_eq("sw_mem_addr", bus.cmt_mem_addr, 32'h2000);
    check_eq("sw_mem_wmask", bus.cmt_mem_wmask, 4'hF);
    check_eq("sw_mem_wdata", bus.cmt_mem_wdata, 32'hDEAD_BEEF);
    check_eq("sw_mem_rmask", bus.cmt_mem_rmask, 4'h0);
    check_eq("sw_order", bus.cmt_order, exp_order);
    exp_order++;
    idle_inputs();
    tick();

    // Writeback to x0 and trap on inst 0.
    cap_in(32'hA0, 32'h0000_0000);
    tick();
    bus.cap_valid = 1'b0;
    tick();
    tick();
    bus.wb_load = 1'b1;
    bus.wb_rd = 5'd0;
    bus.wb_wdata = 32'h55;
    #1;
    check_eq("x0_valid", bus.cmt_valid, 1'b1);
    check_eq("x0_rd_addr", bus.cmt_rd_addr, 5'd0);
    check_eq("x0_rd_wdata", bus.cmt_rd_wdata, 32'd0);
    check_eq("x0_trap", bus.cmt_trap, 1'b1);
    check_eq("x0_order", bus.cmt_order, exp_order);
    bus.wb_rd = 5'd5;
    #1;
    check_eq("x5_rd_addr", bus.cmt_rd_addr, 5'd5);
    check_eq("x5_rd_wdata", bus.cmt_rd_wdata, 32'h55);
    bus.wb_load = 1'b0;
    #1;
    check_eq("noload_rd_addr", bus.cmt_rd_addr, 5'd0);
    exp_order++;
    idle_inputs();
    tick();

    // jal x0,0 at 0x80: self-loop commit; halt only in the detect build.
    cap_in(32'h80, 32'h0000_006F);
    tick();
    bus.cap_valid = 1'b0;
    bus.rdr_valid = 1'b1;
    bus.rdr_target = 32'h80;
    tick();
    bus.rdr_valid = 1'b0;
    tick();
    check_eq("loop_valid", bus.cmt_valid, 1'b1);
    check_eq("loop_pc_wdata", bus.cmt_pc_wdata, 32'h80);
    check_eq("loop_order", bus.cmt_order, exp_order);
    check_eq("loop_halt_same_cycle", bus.halt, 1'b0);
    exp_order++;
    tick();
    check_eq("loop_halt_next", bus.halt, HALT_EN);
    for (int k = 0; k < 3; k++) tick();
    check_eq("loop_halt_sticky", bus.halt, HALT_EN);

    // Reset mid-stream drops in-flight entries and clears order/halt.
    cap_in(32'hB0, 32'h0000_0013);
    tick();
    cap_in(32'hB4, 32'h0000_0013);
    tick();
    bus.cap_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("mrst_valid", bus.cmt_valid, 1'b0);
    check_eq("mrst_halt", bus.halt, 1'b0);
    check_eq("mrst_pc", bus.cmt_pc_rdata, 32'd0);
    tick();
    check_eq("mrst_hold_valid", bus.cmt_valid, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq($sformatf("mrst_drop_c%0d", k), bus.cmt_valid, 1'b0);
    end
    cap_in(32'hC0, 32'h0000_0013);
    tick();
    bus.cap_valid = 1'b0;
    tick();
    tick();
    check_eq("post_rst_valid", bus.cmt_valid, 1'b1);
    check_eq("post_rst_pc", bus.cmt_pc_rdata, 32'hC0);
    check_eq("post_rst_order", bus.cmt_order, 64'd0);
    check_eq("post_rst_halt", bus.halt, 1'b0);
    tick();

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
